cpu_seq: RTL and testbench
==========================

# cpu_seq

Instruction sequencer that drives the `cpu` block's `load`/`s`/`in` handshake and collects its `out`/`N`/`V`/`Z` results. It holds a small program memory written over a simple write port, then on `start` issues each instruction to the CPU in order. For each instruction it waits for the CPU's `w` to drop and return, captures the result, and finally reports completion or timeout. It is the initiator side of the CPU control interface and replaces hand-written stimulus in system-level runs.

## Interface
- `DEPTH`, 16: program memory entries; power of two.
- `AW`, 4: address width, log2(DEPTH).
- `TMO`, 64: maximum cycles spent in one wait state before abort; ≥ 2.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0); forces every register to its reset value immediately.
- `prog_we` in 1: program write strobe; ignored while `busy`=1.
- `prog_addr` in AW: program write address.
- `prog_data` in 16: instruction word written at `prog_addr`.
- `prog_len` in AW+1: number of instructions to run, 0..DEPTH; sampled on `start`.
- `start` in 1: one-cycle run request; ignored while `busy`=1.
- `cpu_w` in 1: CPU wait flag; 1 means CPU is idle in its wait state.
- `cpu_out` in 16, `cpu_N`, `cpu_V`, `cpu_Z` in 1 each: CPU result and status.
- `cpu_load` out 1: instruction-register load strobe to CPU.
- `cpu_s` out 1: CPU start strobe.
- `cpu_in` out 16: instruction word to CPU.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run (normal or aborted).
- `err` out 1: sticky timeout flag; cleared on next accepted `start`.
- `result` out 16: `cpu_out` captured after the most recent instruction.
- `flags` out 3: {N,V,Z} captured with `result`.
- `pc` out AW+1: index of the instruction currently issued, or count completed when idle.

## Operation
- Registered outputs; reset values: `cpu_load`=0, `cpu_s`=0, `cpu_in`=0, `busy`=0, `done`=0, `err`=0, `result`=0, `flags`=0, `pc`=0; state IDLE. Program memory is not reset.
- States: IDLE, LOAD, START, WLOW, WHIGH, CAPT, FIN.
- IDLE:
  - `prog_we` writes `mem[prog_addr]`.
  - `start` with `prog_len`=0 goes to FIN directly (pc=0, no CPU activity).
  - `start` with `prog_len`>0 latches the length, sets pc=0, clears `err`, sets `busy`, and goes to LOAD.
- LOAD:
  - If `cpu_w`=0, hold with `cpu_load`=0 and the timer running.
  - Otherwise drive `cpu_in`=mem[pc] and `cpu_load`=1 for exactly one cycle, then go to START.
- START: `cpu_s`=1 for exactly one cycle (`cpu_in` held), then go to WLOW.
- WLOW: wait for `cpu_w`=0, then go to WHIGH.
- WHIGH: wait for `cpu_w`=1, then go to CAPT.
- CAPT:
  - `result`←`cpu_out`, `flags`←{N,V,Z}, pc←pc+1.
  - If the new pc equals the latched length, go to FIN; else go to LOAD.
- FIN: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- Timeout:
  - A counter clears on entry to LOAD, WLOW and WHIGH.
  - If it reaches TMO-1 while still waiting, set `err`=1 and go to FIN; `pc` holds the failing index.
- `prog_we` while `busy` is dropped. `start` while `busy` is dropped.
- Simultaneous `prog_we` and `start` in IDLE: the write completes first and is visible to the run.
- Reset mid-run: all outputs return to reset values at once, with no partial `done`.

## Timing
- Minimum per-instruction cost is 5 cycles: LOAD, START, WLOW with `cpu_w` already 0 on the next edge, WHIGH for 1 cycle, CAPT.
- `cpu_load` and `cpu_s` are never high in the same cycle; each is high for exactly one cycle per instruction.
- `done` rises exactly one cycle after the CAPT of the last instruction.
- `result`/`flags` update on the CAPT edge and are stable until the next CAPT.
- `start`→`busy`=1: 1 cycle. `start` with `prog_len`=0 → `done`: 2 cycles.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random inputs → all outputs 0, no `cpu_load`/`cpu_s` pulse.
- Program D007, D102, A140 (MOV R0,#7; MOV R1,#2; ADD R2,R1,R0) with `prog_len`=3 against real `cpu` → exactly 3 `cpu_load` pulses and 3 `cpu_s` pulses; `done` pulse with `result`=0x0009, `flags`=000, `pc`=3, `err`=0.
- Append A801 (CMP R1,R0; R1−R0 = 2−7 = −5) with `prog_len`=4 → `flags`=100 (N=1, V=0, Z=0), `pc`=4.
- Stub CPU that never drops `cpu_w` → after START, TMO cycles in WLOW, then `err`=1, `done` pulse, `pc`=0.
- `start` with `prog_len`=0 → `done` 2 cycles later, no CPU strobes. `start` and `prog_we` pulsed mid-run → ignored; memory unchanged.
- Assert `reset` in WHIGH of the 2nd instruction → immediate return to reset values. A fresh `start` then runs from pc=0 correctly.

Source files
------------

// File: rtl/cpu_seq.sv
// Instruction sequencer: holds a small program and issues it to the cpu block
// over its load/s/in handshake, capturing out/N/V/Z after each instruction.
module cpu_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int TMO   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic [15:0]   cpu_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   result,
  output logic [2:0]    flags,
  output logic [AW:0]   pc
);

  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WLOW, WHIGH, CAPT, FIN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   pc_q, pc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cpu_load_q, cpu_load_d;
  logic          cpu_s_q, cpu_s_d;
  logic [15:0]   cpu_in_q, cpu_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   result_q, result_d;
  logic [2:0]    flags_q, flags_d;
  logic          tmr_exp;

  assign tmr_exp = (tmr_q == TMO_LAST);

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pc_d       = pc_q;
    tmr_d      = '0;
    cpu_load_d = 1'b0;
    cpu_s_d    = 1'b0;
    cpu_in_d   = cpu_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    flags_d    = flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = prog_len;
          pc_d  = '0;
          err_d = 1'b0;
          if (prog_len == '0) begin
            state_d = FIN;
          end else begin
            busy_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cpu_w) begin
          cpu_load_d = 1'b1;
          cpu_in_d   = mem[pc_q[AW-1:0]];
          state_d    = START;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      START: begin
        cpu_s_d = 1'b1;
        state_d = WLOW;
      end
      WLOW: begin
        if (!cpu_w) begin
          state_d = WHIGH;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WHIGH: begin
        if (cpu_w) begin
          state_d = CAPT;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CAPT: begin
        result_d = cpu_out;
        flags_d  = {cpu_N, cpu_V, cpu_Z};
        pc_d     = pc_q + 1'b1;
        state_d  = ((pc_q + 1'b1) == len_q) ? FIN : LOAD;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      pc_q       <= '0;
      tmr_q      <= '0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      cpu_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pc_q       <= pc_d;
      tmr_q      <= tmr_d;
      cpu_load_q <= cpu_load_d;
      cpu_s_q    <= cpu_s_d;
      cpu_in_q   <= cpu_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign cpu_load = cpu_load_q;
  assign cpu_s    = cpu_s_q;
  assign cpu_in   = cpu_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized bench for cpu_seq: a behavioural cpu responder plus a program-memory
// reference model predict every load, pulse count, result and status.
module tb_cpu_seq;

  localparam int TMO = 64;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        cpu_w;
  logic [15:0] cpu_out;
  logic        cpu_N, cpu_V, cpu_Z;
  logic        cpu_load, cpu_s;
  logic [15:0] cpu_in;
  logic        busy, done, err;
  logic [15:0] result;
  logic [2:0]  flags;
  logic [4:0]  pc;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_mem [16];
  bit          hang = 1'b0;

  // Written only by the cpu responder.
  int          n_load, n_s, pulse_viol;
  logic [15:0] ld_log [1024];
  logic [15:0] last_resp;
  logic [2:0]  last_nvz;

  cpu_seq #(.DEPTH(16), .AW(4), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start),
    .cpu_w(cpu_w), .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_in(cpu_in),
    .busy(busy), .done(done), .err(err),
    .result(result), .flags(flags), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({cpu_load, cpu_s, busy, done, err, pc}), 32'd0);
    check({tag, "_in"},  32'(cpu_in), 32'd0);
    check({tag, "_res"}, 32'({flags, result}), 32'd0);
  endtask

  // Behavioural cpu: idles with w=1, drops w for a few cycles after each s,
  // then presents a fresh random result. Optionally holds w low at run start.
  initial begin : cpu_model
    int   work;
    int   hold;
    logic prev_busy, prev_load, prev_s;
    work = 0; hold = 0; prev_busy = 1'b0; prev_load = 1'b0; prev_s = 1'b0;
    cpu_w = 1'b1; cpu_out = '0; {cpu_N, cpu_V, cpu_Z} = 3'b000;
    n_load = 0; n_s = 0; pulse_viol = 0; last_resp = '0; last_nvz = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        work = 0; hold = 0; cpu_w = 1'b1;
        prev_busy = 1'b0; prev_load = 1'b0; prev_s = 1'b0;
      end else begin
        if ((cpu_load && cpu_s) || (cpu_load && prev_load) || (cpu_s && prev_s)) pulse_viol++;
        if (busy && !prev_busy && !hang) hold = $urandom_range(0, 6);
        if (cpu_load) begin
          ld_log[n_load % 1024] = cpu_in;
          n_load++;
        end
        if (cpu_s) begin
          n_s++;
          if (!hang) begin
            work  = $urandom_range(1, 5);
            cpu_w = 1'b0;
          end
        end else if (work > 0) begin
          work--;
          if (work == 0) begin
            last_resp = 16'($urandom);
            last_nvz  = 3'($urandom);
            cpu_out   = last_resp;
            {cpu_N, cpu_V, cpu_Z} = last_nvz;
            cpu_w     = 1'b1;
          end
        end else begin
          cpu_w = (hold == 0);
          if (hold > 0) hold--;
        end
        prev_busy = busy; prev_load = cpu_load; prev_s = cpu_s;
      end
    end
  end

  task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    model_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input int len, input bit hang_run, input bit poke, input bit sim_wr);
    int l0, s0, t, t_s;
    l0 = n_load; s0 = n_s; t_s = -1;
    hang = hang_run;
    prog_len = 5'(len);
    start = 1'b1;
    if (sim_wr) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'($urandom);
      model_mem[0] = prog_data;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; t = 1;
    check("busy_rise", 32'(busy), 32'(len != 0));
    while (!done && t < 2000) begin
      if (cpu_s && t_s < 0) t_s = t;
      if (poke && t == 3) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'($urandom);
        prog_data = ~model_mem[prog_addr]; prog_len = 5'($urandom);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0; prog_we = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    $display("run len=%0d hang=%0d cycles=%0d pc=%0d err=%0d result=%h flags=%b",
             len, hang_run, t, pc, err, result, flags);
    if (len == 0) begin
      check("zero_lat",  32'(t), 32'd2);
      check("zero_load", 32'(n_load - l0), 32'd0);
      check("zero_s",    32'(n_s - s0), 32'd0);
      check("zero_pc",   32'(pc), 32'd0);
    end else if (hang_run) begin
      check("to_err",  32'(err), 32'd1);
      check("to_pc",   32'(pc), 32'd0);
      check("to_lat",  32'(t - t_s), 32'(TMO + 1));
      check("to_load", 32'(n_load - l0), 32'd1);
      check("to_s",    32'(n_s - s0), 32'd1);
      check("to_res",  32'({flags, result}), 32'({last_nvz, last_resp}));
    end else begin
      check("run_err",    32'(err), 32'd0);
      check("run_pc",     32'(pc), 32'(len));
      check("run_result", 32'(result), 32'(last_resp));
      check("run_flags",  32'(flags), 32'(last_nvz));
      check("run_load",   32'(n_load - l0), 32'(len));
      check("run_s",      32'(n_s - s0), 32'(len));
      for (int i = 0; i < len; i++)
        check("ld_seq", 32'(ld_log[(l0 + i) % 1024]), 32'(model_mem[i]));
    end
    hang = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'({done, busy}), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int seen, b;
    reset = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; prog_len = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("reset");
      start = 1'($urandom); prog_we = 1'($urandom);
      prog_addr = 4'($urandom); prog_data = 16'($urandom); prog_len = 5'($urandom);
    end
    @(negedge clk);
    check_zero("reset");
    reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) write_mem(4'(i), 16'($urandom));
    write_mem(4'd0, 16'hD007);
    write_mem(4'd1, 16'hD102);
    write_mem(4'd2, 16'hA140);
    run_prog(3, 1'b0, 1'b0, 1'b0);
    write_mem(4'd3, 16'hA801);
    run_prog(4, 1'b0, 1'b0, 1'b0);

    run_prog(2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    run_prog(0, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int nwr;
      nwr = $urandom_range(1, 6);
      for (int k = 0; k < nwr; k++) write_mem(4'($urandom), 16'($urandom));
      run_prog($urandom_range(1, 16), 1'b0, (it % 3) == 1, (it % 3) == 2);
      if ((it % 3) == 1) begin
        repeat (3) @(negedge clk);
        check("no_rerun", 32'({busy, done}), 32'd0);
      end
    end

    // Abort a run while the 2nd instruction waits for w to return.
    prog_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 0; b = 0;
    while (seen < 2 && b < 500) begin
      if (cpu_s) seen++;
      if (seen < 2) begin
        @(negedge clk);
        b++;
      end
    end
    check("rst_reach", 32'(seen), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      check_zero("midrst_hold");
    end
    reset = 1'b1;
    @(negedge clk);
    run_prog(4, 1'b0, 1'b0, 1'b0);

    check("pulse_shape", 32'(pulse_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
